// File: rtl/pr_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload countdown, level interrupt gated by the IM bit.
module pr_timer #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic sel;
  logic wr_ctrl;
  logic wr_preset;
  logic unused_addr_lsb;

  assign sel             = (addr[31:4] == BASE[31:4]);
  assign wr_ctrl         = sel & we & (addr[3:2] == 2'd0);
  assign wr_preset       = sel & we & (addr[3:2] == 2'd1);
  assign unused_addr_lsb = ^addr[1:0];

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = '0;
      endcase
    end
  end

  // Ordering encodes the race rules: bus clear of pending is overridden by the
  // CNT->INT set, and a bus CTRL write overrides the INT-state EN clear.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    if (wr_ctrl || wr_preset) pend_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          pend_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (ctrl_q[2:1] == 2'd1) begin
          pend_d  = 1'b0;
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_ctrl)   ctrl_d   = wdata[3:0];
    if (wr_preset) preset_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  assign irq = ctrl_q[3] & pend_q;

endmodule

// File: tb/tb_pr_timer.sv
// Bench for pr_timer: directed scenarios with fixed expectations, then random
// bus traffic compared every cycle against a behavioural timer model.
module tb_pr_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  pr_timer #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: timer phase plus the architectural registers.
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_FIRE = 3;

  int          m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_irq();
    return {31'd0, m_pend & m_ctrl[3]};
  endfunction

  task automatic model_step();
    bit          hit;
    int          reg_ix;
    bit          reload_mode;
    bit          fired;
    int          nxt_phase;
    logic [3:0]  nxt_ctrl;
    logic [31:0] nxt_preset;
    logic [31:0] nxt_count;
    if (reset) begin
      m_phase = PH_IDLE; m_ctrl = '0; m_preset = '0; m_count = '0; m_pend = 0;
      return;
    end
    hit         = we && (addr[31:4] == BASE[31:4]);
    reg_ix      = int'(addr[3:2]);
    reload_mode = (m_ctrl[2:1] == 2'd1);
    fired       = 0;
    nxt_phase   = m_phase;
    nxt_ctrl    = m_ctrl;
    nxt_preset  = m_preset;
    nxt_count   = m_count;
    if (m_phase == PH_IDLE) begin
      if (m_ctrl[0]) nxt_phase = PH_LOAD;
    end else if (m_phase == PH_LOAD) begin
      nxt_count = m_preset;
      nxt_phase = PH_RUN;
    end else if (m_phase == PH_RUN) begin
      if (!m_ctrl[0]) nxt_phase = PH_IDLE;
      else if (m_count > 32'd1) nxt_count = m_count - 32'd1;
      else begin
        nxt_count = 32'd0;
        nxt_phase = PH_FIRE;
        fired     = 1;
      end
    end else begin
      if (reload_mode) nxt_phase = PH_LOAD;
      else begin
        nxt_ctrl[0] = 1'b0;
        nxt_phase   = PH_IDLE;
      end
    end
    if (fired) m_pend = 1;
    else if ((hit && reg_ix < 2) || (m_phase == PH_FIRE && reload_mode)) m_pend = 0;
    if (hit && reg_ix == 0) nxt_ctrl = wdata[3:0];
    if (hit && reg_ix == 1) nxt_preset = wdata;
    m_phase  = nxt_phase;
    m_ctrl   = nxt_ctrl;
    m_preset = nxt_preset;
    m_count  = nxt_count;
  endtask

  task automatic set_bus(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr  = a;
    we    = w;
    wdata = d;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_irq", {31'd0, irq}, m_irq());
    check("model_rdata", rdata, m_read(addr));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    set_bus(a, 1'b1, d);
    tick();
    we = 1'b0;
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    set_bus(a, 1'b0, 32'd0);
    check(tag, rdata, exp);
  endtask

  initial begin
    logic [31:0] reload_cnt [5];
    reload_cnt = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1};

    reset = 1'b1; we = 1'b0; addr = BASE; wdata = '0;
    m_phase = PH_IDLE; m_ctrl = '0; m_preset = '0; m_count = '0; m_pend = 0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) expect_rd("reset_reg", BASE + 32'(4 * i), 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    expect_rd("out_of_range", 32'h0000_7F10, 32'd0);

    // One-shot, IM=1
    wr(BASE + 32'h4, 32'd5);
    wr(BASE, 32'h9);
    set_bus(BASE + 32'h8, 1'b0, 32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      check("m0_count", rdata, 32'(5 - k));
      check("m0_irq", {31'd0, irq}, {31'd0, k == 5});
    end
    tick();
    expect_rd("m0_ctrl_after", BASE, 32'h8);
    check("m0_irq_hold", {31'd0, irq}, 32'd1);
    repeat (3) tick();
    check("m0_irq_hold2", {31'd0, irq}, 32'd1);
    wr(BASE, 32'h0);
    check("m0_irq_clear", {31'd0, irq}, 32'd0);

    // Auto-reload
    wr(BASE + 32'h4, 32'd3);
    wr(BASE, 32'hB);
    set_bus(BASE + 32'h8, 1'b0, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("m1_irq", {31'd0, irq}, {31'd0, (k % 5) == 0});
      check("m1_count", rdata, reload_cnt[k % 5]);
    end
    wr(BASE, 32'h0);
    repeat (3) tick();

    // IM=0 masks, CTRL write clears pending
    wr(BASE + 32'h4, 32'd2);
    wr(BASE, 32'h1);
    repeat (6) begin
      tick();
      check("mask_irq", {31'd0, irq}, 32'd0);
    end
    expect_rd("mask_ctrl", BASE, 32'h0);
    wr(BASE, 32'h8);
    check("wclr_irq", {31'd0, irq}, 32'd0);
    tick();
    check("wclr_irq2", {31'd0, irq}, 32'd0);
    wr(BASE, 32'h0);

    // Stop mid-count, reload on re-enable
    wr(BASE + 32'h4, 32'd100);
    wr(BASE, 32'h1);
    set_bus(BASE + 32'h8, 1'b0, 32'd0);
    repeat (10) tick();
    check("mid_count", rdata, 32'd92);
    wr(BASE, 32'h0);
    expect_rd("freeze0", BASE + 32'h8, 32'd91);
    tick();
    check("freeze1", rdata, 32'd91);
    tick();
    check("freeze2", rdata, 32'd91);
    wr(BASE + 32'h4, 32'd7);
    wr(BASE, 32'h1);
    expect_rd("restart_idle", BASE + 32'h8, 32'd91);
    tick();
    check("restart_load", rdata, 32'd91);
    tick();
    check("restart_reload", rdata, 32'd7);
    wr(BASE, 32'h0);
    repeat (3) tick();

    // CPU CTRL write beats the one-shot EN clear
    wr(BASE + 32'h4, 32'd1);
    wr(BASE, 32'h9);
    set_bus(BASE + 32'h8, 1'b0, 32'd0);
    repeat (3) tick();
    check("race_pre_irq", {31'd0, irq}, 32'd1);
    wr(BASE, 32'h9);
    expect_rd("race_ctrl", BASE, 32'h9);
    check("race_irq_cleared", {31'd0, irq}, 32'd0);
    set_bus(BASE + 32'h8, 1'b0, 32'd0);
    tick(); tick();
    check("race_recount", rdata, 32'd1);
    tick();
    check("race_refire", {31'd0, irq}, 32'd1);
    wr(BASE, 32'h0);

    // Pending set beats a same-cycle PRESET write clear
    wr(BASE + 32'h4, 32'd2);
    wr(BASE, 32'h9);
    set_bus(BASE + 32'h8, 1'b0, 32'd0);
    repeat (3) tick();
    check("setwin_count", rdata, 32'd1);
    wr(BASE + 32'h4, 32'd5);
    check("setwin_irq", {31'd0, irq}, 32'd1);
    wr(BASE, 32'h0);
    repeat (2) tick();

    // Full-range preset
    wr(BASE + 32'h4, 32'hFFFF_FFFF);
    wr(BASE, 32'h1);
    set_bus(BASE + 32'h8, 1'b0, 32'd0);
    tick(); tick();
    check("full_load", rdata, 32'hFFFF_FFFF);
    tick();
    check("full_dec", rdata, 32'hFFFF_FFFE);
    wr(BASE, 32'h0);
    repeat (2) tick();

    // Reset mid-count with a simultaneous write
    wr(BASE + 32'h4, 32'd50);
    wr(BASE, 32'h9);
    set_bus(BASE + 32'h8, 1'b0, 32'd0);
    repeat (12) tick();
    check("rst_pre_count", rdata, 32'd40);
    reset = 1'b1;
    set_bus(BASE, 1'b1, 32'h9);
    tick();
    reset = 1'b0;
    we = 1'b0;
    for (int i = 0; i < 4; i++) expect_rd("rst_reg", BASE + 32'(4 * i), 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    wr(BASE + 32'h4, 32'd20);
    set_bus(BASE + 32'h8, 1'b0, 32'd0);
    repeat (4) tick();
    check("rst_no_count", rdata, 32'd0);
    wr(BASE + 32'h8, 32'h1234);
    expect_rd("count_ro", BASE + 32'h8, 32'd0);
    wr(BASE + 32'hC, 32'hFFFF);
    expect_rd("reserved_rd", BASE + 32'hC, 32'd0);
    expect_rd("reserved_ctrl", BASE, 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [1:0]  idx;
      logic [1:0]  lo;
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      idx   = 2'($urandom_range(0, 3));
      lo    = 2'($urandom_range(0, 3));
      a     = ($urandom_range(0, 9) == 0) ? 32'($urandom) : {BASE[31:4], idx, lo};
      w     = ($urandom_range(0, 99) < 25);
      d     = (idx == 2'd1) ? 32'($urandom_range(0, 6)) : 32'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      set_bus(a, w, d);
      check("rand_rdata", rdata, m_read(a));
      tick();
    end
    reset = 1'b0;
    we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
